ienc: RTL and testbench

Instruction encoder/loader for the 16-bit PU: the writer-side counterpart of the instruction decoder. It accepts one symbolic instruction per handshake (instruction kind plus register, ALU-op, condition and immediate fields) and packs it into the 16-bit ISA word. It writes consecutive words into instruction memory from address 0 and terminates the program with a HALT word. It sits between the host/test loader and the instruction-memory write port, ahead of PU start.

---
 rtl/ienc_pkg.sv | 76 +++++++
 rtl/ienc_if.sv | 35 +++
 rtl/ienc_pack.sv | 71 +++++++
 rtl/ienc.sv | 138 +++++++++++++
 tb/tb_ienc.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ienc_pkg.sv
// ienc_pkg: shared definitions for the instruction encoder/loader.
//   kind_t    - symbolic instruction kinds accepted by the encoder (5-bit code)
//   cond_t    - branch condition codes
//   aluop_t   - ALU operation codes (same numbering as the ALU)
//   state_t   - loader FSM states
//   HALT_WORD / NOP_WORD - fixed ISA words
//   is_iv_kind() - kinds whose immediate is only 4 bits wide
package ienc_pkg;

  typedef enum logic [4:0] {
    K_NOP   = 5'd0,
    K_HALT  = 5'd1,
    K_CDM   = 5'd2,
    K_RESET = 5'd3,
    K_BST   = 5'd4,
    K_BRT   = 5'd5,
    K_INC   = 5'd6,
    K_DEC   = 5'd7,
    K_RSL   = 5'd8,
    K_RSR   = 5'd9,
    K_CAL   = 5'd10,
    K_EVA   = 5'd11,
    K_JPR   = 5'd12,
    K_SMR   = 5'd13,
    K_LMR   = 5'd14,
    K_SMI   = 5'd15,
    K_JPI   = 5'd16,
    K_JPC   = 5'd17,
    K_JPA   = 5'd18,
    K_LISR  = 5'd19,
    K_LIL   = 5'd20,
    K_LIH   = 5'd21,
    K_LI    = 5'd22,
    K_LMI   = 5'd23,
    K_LMA   = 5'd24,
    K_SMA   = 5'd25,
    K_CALI  = 5'd26,
    K_EVAI  = 5'd27,
    K_CALC  = 5'd28
  } kind_t;

  typedef enum logic [1:0] {
    C_UC = 2'b00,
    C_ZE = 2'b01,
    C_CA = 2'b10,
    C_OD = 2'b11
  } cond_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_ADC = 4'd2,  OP_SBC = 4'd3,
    OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7,
    OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_ROL = 4'd10, OP_ROR = 4'd11,
    OP_PSA = 4'd12, OP_PSB = 4'd13, OP_THA = 4'd14, OP_THB = 4'd15
  } aluop_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HALT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] HALT_WORD = 16'h0001;
  localparam logic [15:0] NOP_WORD  = 16'h0000;

  // Kinds that carry a 4-bit immediate; a nonzero imm[7:4] on these is
  // an encoding error rather than something to silently truncate.
  function automatic logic is_iv_kind(input logic [4:0] k);
    case (k)
      K_CDM, K_BST, K_BRT, K_INC, K_DEC, K_RSL, K_RSR,
      K_LISR, K_CALI, K_EVAI, K_CALC: is_iv_kind = 1'b1;
      default:                        is_iv_kind = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ienc_if.sv
// ienc_if: host-side load bus plus instruction-memory write port of ienc.
//   master - host/test loader: drives session control and instruction fields
//   slave  - the encoder: drives in_ready, imem write port and status
interface ienc_if #(
  parameter int AW = 8
);
  logic          start;
  logic          fin;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    kind;
  logic [1:0]    rw;
  logic [1:0]    ra;
  logic [1:0]    rb;
  logic [3:0]    op;
  logic [1:0]    cnd;
  logic          p;
  logic [7:0]    imm;
  logic          imwe;
  logic [AW-1:0] imad;
  logic [15:0]   imd;
  logic [AW-1:0] count;
  logic          done;
  logic          err;

  modport master (
    output start, fin, in_valid, kind, rw, ra, rb, op, cnd, p, imm,
    input  in_ready, imwe, imad, imd, count, done, err
  );

  modport slave (
    input  start, fin, in_valid, kind, rw, ra, rb, op, cnd, p, imm,
    output in_ready, imwe, imad, imd, count, done, err
  );
endinterface

// File: rtl/ienc_pack.sv
// ienc_pack: purely combinational packer from symbolic instruction fields
// to a 16-bit ISA word.
//   kind_i          - instruction kind code
//   rw_i/ra_i/rb_i  - register fields
//   op_i            - ALU op
//   cnd_i/p_i       - branch condition and polarity
//   imm_i           - 8-bit immediate (low 4 bits for iv kinds)
//   word_o          - packed word
//   legal_o         - 0 for an unknown kind or an oversized 4-bit immediate
module ienc_pack
  import ienc_pkg::*;
(
  input  logic [4:0]  kind_i,
  input  logic [1:0]  rw_i,
  input  logic [1:0]  ra_i,
  input  logic [1:0]  rb_i,
  input  logic [3:0]  op_i,
  input  logic [1:0]  cnd_i,
  input  logic        p_i,
  input  logic [7:0]  imm_i,
  output logic [15:0] word_o,
  output logic        legal_o
);

  logic [2:0] f;
  logic [3:0] iv4;

  assign f   = {cnd_i, p_i};
  assign iv4 = imm_i[3:0];

  always_comb begin
    word_o  = NOP_WORD;
    legal_o = 1'b1;
    case (kind_i)
      K_NOP:   word_o = NOP_WORD;
      K_HALT:  word_o = HALT_WORD;
      K_CDM:   word_o = {12'h008, iv4};
      K_RESET: word_o = {8'h01, 2'b00, rw_i, 4'h0};
      K_BST:   word_o = {5'b00000, 3'b010, rw_i, ra_i, iv4};
      K_BRT:   word_o = {5'b00000, 3'b011, rw_i, ra_i, iv4};
      K_INC:   word_o = {5'b00000, 3'b100, rw_i, ra_i, iv4};
      K_DEC:   word_o = {5'b00000, 3'b101, rw_i, ra_i, iv4};
      K_RSL:   word_o = {5'b00000, 3'b110, rw_i, ra_i, iv4};
      K_RSR:   word_o = {5'b00000, 3'b111, rw_i, ra_i, iv4};
      K_CAL:   word_o = {6'b000010, rw_i, op_i, ra_i, rb_i};
      K_EVA:   word_o = {8'b00001100, op_i, ra_i, rb_i};
      K_JPR:   word_o = {5'b00010, f, op_i, ra_i, rb_i};
      K_SMR:   word_o = {12'b0010_1000_0000, ra_i, rb_i};
      K_LMR:   word_o = {6'b001100, rw_i, 6'b000000, rb_i};
      K_SMI:   word_o = {6'b010000, rb_i, imm_i};
      K_JPI:   word_o = {5'b01001, f, imm_i};
      K_JPC:   word_o = {5'b01011, f, imm_i};
      K_JPA:   word_o = {3'b011, ra_i, f, imm_i};
      K_LISR:  word_o = {4'b1000, rw_i, 6'b000000, iv4};
      K_LIL:   word_o = {4'b1000, rw_i, 2'b01, imm_i};
      K_LIH:   word_o = {4'b1000, rw_i, 2'b10, imm_i};
      K_LI:    word_o = {4'b1000, rw_i, 2'b11, imm_i};
      K_LMI:   word_o = {6'b100101, rw_i, imm_i};
      K_LMA:   word_o = {4'b1010, rw_i, ra_i, imm_i};
      K_SMA:   word_o = {4'b1011, ra_i, rb_i, imm_i};
      K_CALI:  word_o = {4'b1100, rw_i, ra_i, op_i, iv4};
      K_EVAI:  word_o = {6'b110100, ra_i, op_i, iv4};
      K_CALC:  word_o = {3'b111, rw_i, f, op_i, iv4};
      default: legal_o = 1'b0;
    endcase
    if (is_iv_kind(kind_i) && (imm_i[7:4] != 4'h0)) begin
      legal_o = 1'b0;
    end
  end

endmodule

// File: rtl/ienc.sv
// ienc: instruction encoder/loader. Accepts one symbolic instruction per
// handshake, packs it and writes consecutive words into instruction memory
// from address 0; a session is closed by appending a HALT word.
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - ienc_if.slave: start/fin session control, in_valid/in_ready
//          handshake with instruction fields, imwe/imad/imd write port,
//          count/done/err status
module ienc
  import ienc_pkg::*;
#(
  parameter int AW = 8
) (
  input logic   clk,
  input logic   rst,
  ienc_if.slave bus
);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [AW-1:0] count_q, count_d;
  logic          err_q,   err_d;
  logic          imwe_q,  imwe_d;
  logic [AW-1:0] imad_q,  imad_d;
  logic [15:0]   imd_q,   imd_d;

  logic          in_ready;
  logic          done;
  logic          accept;
  logic          opening;
  logic [15:0]   pk_word;
  logic          pk_legal;

  ienc_pack u_pack (
    .kind_i  (bus.kind),
    .rw_i    (bus.rw),
    .ra_i    (bus.ra),
    .rb_i    (bus.rb),
    .op_i    (bus.op),
    .cnd_i   (bus.cnd),
    .p_i     (bus.p),
    .imm_i   (bus.imm),
    .word_o  (pk_word),
    .legal_o (pk_legal)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_LOAD;
      S_LOAD:         if (bus.fin)   state_d = S_HALT;
      S_HALT:         state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // FSM outputs. The top address is kept free so HALT always fits, and
  // fin masks in_ready so an instruction offered alongside fin is not taken.
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_LOAD:  in_ready = !bus.fin && (addr_q != {AW{1'b1}});
      S_DONE:  done     = 1'b1;
      default: ;
    endcase
  end

  assign accept  = bus.in_valid && in_ready;
  assign opening = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;

  // Write-port / counter next state. The HALT word is registered on the
  // fin edge so that it appears on the port during the HALT state.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    imwe_d  = 1'b0;
    imad_d  = imad_q;
    imd_d   = imd_q;
    if (opening) begin
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else if ((state_q == S_LOAD) && bus.fin) begin
      imwe_d  = 1'b1;
      imad_d  = addr_q;
      imd_d   = HALT_WORD;
      count_d = count_q + 1'b1;
    end else if (accept) begin
      if (pk_legal) begin
        imwe_d  = 1'b1;
        imad_d  = addr_q;
        imd_d   = pk_word;
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 1'b1;
      end else begin
        // Rejected words are consumed but leave no trace except err.
        err_d = 1'b1;
      end
    end
  end

  // Write-port / counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      imwe_q  <= 1'b0;
      imad_q  <= '0;
      imd_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      imwe_q  <= imwe_d;
      imad_q  <= imad_d;
      imd_q   <= imd_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.imwe     = imwe_q;
  assign bus.imad     = imad_q;
  assign bus.imd      = imd_q;
  assign bus.count    = count_q;
  assign bus.done     = done;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ienc.sv
module tb_ienc;
  import ienc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ienc_if #(.AW(8)) ia ();
  ienc_if #(.AW(2)) ib ();

  ienc #(.AW(8)) ua (.clk(clk), .rst(rst), .bus(ia));
  ienc #(.AW(2)) ub (.clk(clk), .rst(rst), .bus(ib));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int addr_a = 0;
  int addr_b = 0;

  typedef struct {
    int          addr;
    logic [15:0] data;
    int          at;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  wr_t ea, eb;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: every write must match the oldest expected entry,
  // including the cycle it was due in.
  always @(negedge clk) begin
    if (ia.imwe === 1'b1) begin
      tests++;
      assert (qa.size() > 0) else begin
        fails++;
        $error("FAIL wrA_unexpected observed addr=%0h data=%h expected no write", ia.imad, ia.imd);
      end
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        chk("wrA_addr", 32'(ia.imad), ea.addr);
        chk("wrA_data", 32'(ia.imd), 32'(ea.data));
        chk("wrA_cycle", cyc, ea.at);
      end
    end
    if (ib.imwe === 1'b1) begin
      tests++;
      assert (qb.size() > 0) else begin
        fails++;
        $error("FAIL wrB_unexpected observed addr=%0h data=%h expected no write", ib.imad, ib.imd);
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        chk("wrB_addr", 32'(ib.imad), eb.addr);
        chk("wrB_data", 32'(ib.imd), 32'(eb.data));
        chk("wrB_cycle", cyc, eb.at);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue_a(input logic [4:0] k, input logic [1:0] rw, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [3:0] op, input logic [1:0] cnd,
                         input logic p, input logic [7:0] imm, input bit legal,
                         input logic [15:0] exp);
    ia.kind = k; ia.rw = rw; ia.ra = ra; ia.rb = rb; ia.op = op;
    ia.cnd = cnd; ia.p = p; ia.imm = imm; ia.in_valid = 1'b1;
    if (legal) begin
      qa.push_back('{addr_a, exp, cyc + 1});
      addr_a++;
    end
    @(negedge clk);
    chk("rdyA", 32'(ia.in_ready), 1);
    step();
    ia.in_valid = 1'b0;
  endtask

  task automatic issue_b(input logic [4:0] k, input logic [1:0] rw, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [3:0] op, input logic [1:0] cnd,
                         input logic p, input logic [7:0] imm, input logic [15:0] exp);
    ib.kind = k; ib.rw = rw; ib.ra = ra; ib.rb = rb; ib.op = op;
    ib.cnd = cnd; ib.p = p; ib.imm = imm; ib.in_valid = 1'b1;
    qb.push_back('{addr_b, exp, cyc + 1});
    addr_b++;
    @(negedge clk);
    chk("rdyB", 32'(ib.in_ready), 1);
    step();
    ib.in_valid = 1'b0;
  endtask

  task automatic start_a();
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    addr_a = 0;
  endtask

  task automatic fin_a(input int exp_count);
    ia.fin = 1'b1;
    qa.push_back('{addr_a, HALT_WORD, cyc + 1});
    @(negedge clk);
    chk("finA_rdy", 32'(ia.in_ready), 0);
    step();
    ia.fin = 1'b0;
    @(negedge clk);
    chk("finA_done_early", 32'(ia.done), 0);
    step();
    @(negedge clk);
    chk("finA_done", 32'(ia.done), 1);
    chk("finA_count", 32'(ia.count), exp_count);
    chk("finA_rdy_after", 32'(ia.in_ready), 0);
    step();
  endtask

  task automatic check_zero_a(input string tag);
    chk({tag, "_rdy"},   32'(ia.in_ready), 0);
    chk({tag, "_imwe"},  32'(ia.imwe), 0);
    chk({tag, "_imad"},  32'(ia.imad), 0);
    chk({tag, "_imd"},   32'(ia.imd), 0);
    chk({tag, "_count"}, 32'(ia.count), 0);
    chk({tag, "_done"},  32'(ia.done), 0);
    chk({tag, "_err"},   32'(ia.err), 0);
  endtask

  initial begin
    ia.start = 0; ia.fin = 0; ia.in_valid = 0; ia.kind = 0; ia.rw = 0; ia.ra = 0;
    ia.rb = 0; ia.op = 0; ia.cnd = 0; ia.p = 0; ia.imm = 0;
    ib.start = 0; ib.fin = 0; ib.in_valid = 0; ib.kind = 0; ib.rw = 0; ib.ra = 0;
    ib.rb = 0; ib.op = 0; ib.cnd = 0; ib.p = 0; ib.imm = 0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_a("rstA");
    chk("rstB_rdy", 32'(ib.in_ready), 0);
    step();
    rst = 1'b0;

    // fin outside a session does nothing
    ia.fin = 1'b1;
    step();
    ia.fin = 1'b0;
    step();
    @(negedge clk);
    chk("idle_fin_done", 32'(ia.done), 0);
    chk("idle_rdy", 32'(ia.in_ready), 0);

    // Session 1: single INC
    step();
    start_a();
    @(negedge clk);
    chk("s1_rdy", 32'(ia.in_ready), 1);
    chk("s1_count0", 32'(ia.count), 0);
    step();
    issue_a(K_INC, 2'd2, 2'd0, 2'd0, 4'd0, C_UC, 1'b0, 8'h01, 1'b1, 16'h0481);
    @(negedge clk);
    chk("s1_count1", 32'(ia.count), 1);
    step();
    fin_a(2);

    // Session 2: back-to-back JPA, CALC, then HALT at addr 2
    start_a();
    @(negedge clk);
    chk("s2_done_clr", 32'(ia.done), 0);
    chk("s2_count_clr", 32'(ia.count), 0);
    step();
    issue_a(K_JPA, 2'd0, 2'd1, 2'd0, 4'd0, C_ZE, 1'b1, 8'h10, 1'b1, 16'h6B10);
    issue_a(K_CALC, 2'd2, 2'd0, 2'd0, OP_SUB, C_OD, 1'b0, 8'h01, 1'b1, 16'hF611);
    fin_a(3);

    // Session 3: rejections, err, ignored start, fin with in_valid held
    start_a();
    issue_a(K_CALI, 2'd1, 2'd1, 2'd0, OP_ADD, C_UC, 1'b0, 8'h1F, 1'b0, 16'h0000);
    issue_a(5'd31, 2'd0, 2'd0, 2'd0, 4'd0, C_UC, 1'b0, 8'h00, 1'b0, 16'h0000);
    @(negedge clk);
    chk("s3_err", 32'(ia.err), 1);
    chk("s3_count_rej", 32'(ia.count), 0);
    step();
    issue_a(K_LI, 2'd1, 2'd0, 2'd0, 4'd0, C_UC, 1'b0, 8'hFF, 1'b1, 16'h87FF);
    issue_a(K_CALC, 2'd3, 2'd0, 2'd0, OP_SUB, C_OD, 1'b0, 8'h01, 1'b1, 16'hFE11);
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    issue_a(K_CDM, 2'd0, 2'd0, 2'd0, 4'd0, C_UC, 1'b0, 8'h05, 1'b1, 16'h0085);
    issue_a(K_LISR, 2'd1, 2'd0, 2'd0, 4'd0, C_UC, 1'b0, 8'h20, 1'b0, 16'h0000);
    issue_a(K_SMA, 2'd0, 2'd1, 2'd2, 4'd0, C_UC, 1'b0, 8'h34, 1'b1, 16'hB634);
    @(negedge clk);
    chk("s3_err_sticky", 32'(ia.err), 1);
    step();
    ia.kind = K_NOP; ia.imm = 8'h00; ia.in_valid = 1'b1;
    fin_a(5);
    ia.in_valid = 1'b0;

    // Session 4: reset right after an accept aborts everything
    start_a();
    @(negedge clk);
    chk("s4_err_clr", 32'(ia.err), 0);
    step();
    issue_a(5'd30, 2'd0, 2'd0, 2'd0, 4'd0, C_UC, 1'b0, 8'h00, 1'b0, 16'h0000);
    issue_a(K_LIL, 2'd0, 2'd0, 2'd0, 4'd0, C_UC, 1'b0, 8'h12, 1'b1, 16'h8112);
    rst = 1'b1;
    step();
    @(negedge clk);
    check_zero_a("abortA");
    step();
    rst = 1'b0;
    start_a();
    issue_a(K_LMA, 2'd1, 2'd2, 2'd0, 4'd0, C_UC, 1'b0, 8'h9C, 1'b1, 16'hA69C);
    fin_a(2);

    // Small memory: three words fill it, the last slot is kept for HALT
    ib.start = 1'b1;
    step();
    ib.start = 1'b0;
    addr_b = 0;
    issue_b(K_LIH, 2'd3, 2'd0, 2'd0, 4'd0, C_UC, 1'b0, 8'hAB, 16'h8EAB);
    issue_b(K_SMI, 2'd0, 2'd0, 2'd1, 4'd0, C_UC, 1'b0, 8'h55, 16'h4155);
    issue_b(K_NOP, 2'd0, 2'd0, 2'd0, 4'd0, C_UC, 1'b0, 8'h00, 16'h0000);
    ib.kind = K_LI; ib.rw = 2'd2; ib.imm = 8'h77; ib.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("fullB_rdy", 32'(ib.in_ready), 0);
      step();
    end
    ib.in_valid = 1'b0;
    ib.fin = 1'b1;
    qb.push_back('{3, HALT_WORD, cyc + 1});
    step();
    ib.fin = 1'b0;
    step();
    @(negedge clk);
    chk("fullB_done", 32'(ib.done), 1);

    repeat (3) step();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
